fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 31 +++
 rtl/fetch_unit.sv | 116 +++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory request/response, decode queue head,
// redirect input and status flags.
interface fetch_unit_if;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        flush_busy;
   logic        proto_err;

   modport master (
      output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
             flush_busy, proto_err,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
             redirect_valid, redirect_pc
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
             flush_busy, proto_err,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
             redirect_valid, redirect_pc
   );
endinterface

// File: rtl/fetch_unit.sv
// Credit-based instruction fetcher: issues word fetches while outstanding+queued < DEPTH,
// buffers in-order responses in a FIFO and drops stale responses after a redirect.
//   state   | meaning
//   S_ISSUE | credit available, request may be presented
//   S_STALL | outstanding + queued entries fill the queue, no request
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 4
) (
   input logic        clk,
   input logic        rst,
   fetch_unit_if.master bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

   typedef enum logic {S_ISSUE, S_STALL} state_t;

   state_t            r_state;
   logic [31:0]       r_fetch_pc;
   logic [31:0]       r_rsp_pc;
   logic [CW-1:0]     r_outstanding;
   logic [CW-1:0]     r_drop_cnt;
   logic [CW-1:0]     r_count;
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic              r_proto_err;
   logic [31:0]       r_mem_pc   [DEPTH];
   logic [31:0]       r_mem_data [DEPTH];

   logic              w_req_valid;
   logic              w_issue;
   logic              w_rsp;
   logic              w_spurious;
   logic              w_push;
   logic              w_pop;
   logic [31:0]       w_redirect_pc;
   logic [CW-1:0]     w_outstanding_nxt;
   logic [CW-1:0]     w_count_nxt;
   logic [CW-1:0]     w_drop_nxt;
   logic [CW:0]       w_sum_nxt;
   state_t            w_state_nxt;

   // Request is gated by rst so it stays low while the block is held in reset.
   assign w_req_valid   = rst && (r_state == S_ISSUE) && !bus.redirect_valid;
   assign w_issue       = w_req_valid && bus.imem_req_ready;
   assign w_rsp         = bus.imem_rsp_valid && (r_outstanding != '0);
   assign w_spurious    = bus.imem_rsp_valid && (r_outstanding == '0);
   assign w_push        = w_rsp && !bus.redirect_valid && (r_drop_cnt == '0);
   assign w_pop         = (r_count != '0) && bus.inst_ready;
   assign w_redirect_pc = bus.redirect_pc & 32'hFFFF_FFFC;

   always_comb begin
      w_outstanding_nxt = r_outstanding + CW'(w_issue) - CW'(w_rsp);
      w_count_nxt       = r_count + CW'(w_push) - CW'(w_pop);
      w_drop_nxt        = r_drop_cnt;
      if (bus.redirect_valid) begin
         w_count_nxt = '0;
         // No issue is possible in a redirect cycle, so this is outstanding minus any arrival.
         w_drop_nxt  = w_outstanding_nxt;
      end else if (w_rsp && (r_drop_cnt != '0)) begin
         w_drop_nxt  = r_drop_cnt - CW'(1);
      end
      w_sum_nxt   = {1'b0, w_outstanding_nxt} + {1'b0, w_count_nxt};
      w_state_nxt = (w_sum_nxt < DEPTH_L) ? S_ISSUE : S_STALL;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= S_ISSUE;
         r_fetch_pc    <= RESET_PC;
         r_rsp_pc      <= RESET_PC;
         r_outstanding <= '0;
         r_drop_cnt    <= '0;
         r_count       <= '0;
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_proto_err   <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_outstanding <= w_outstanding_nxt;
         r_drop_cnt    <= w_drop_nxt;
         r_count       <= w_count_nxt;
         if (w_spurious) r_proto_err <= 1'b1;
         if (bus.redirect_valid) begin
            r_fetch_pc <= w_redirect_pc;
            r_rsp_pc   <= w_redirect_pc;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
         end else begin
            if (w_issue) r_fetch_pc <= r_fetch_pc + 32'd4;
            if (w_push) begin
               r_rsp_pc <= r_rsp_pc + 32'd4;
               r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_pc[r_wr_ptr]   <= r_rsp_pc;
         r_mem_data[r_wr_ptr] <= bus.imem_rsp_data;
      end
   end

   assign bus.imem_req_valid = w_req_valid;
   assign bus.imem_req_addr  = r_fetch_pc;
   assign bus.inst_valid     = (r_count != '0);
   assign bus.inst_data      = r_mem_data[r_rd_ptr];
   assign bus.inst_pc        = r_mem_pc[r_rd_ptr];
   assign bus.flush_busy     = (r_drop_cnt != '0);
   assign bus.proto_err      = r_proto_err;
endmodule
